// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor_if: CPU snoop signals and trace readout port of the trace monitor
interface cpu_trace_monitor_if #(
    parameter int PC_W   = 9,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              fetch;
    logic [PC_W-1:0]   pc;
    logic              halt;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              rd_req;
    logic [PC_W-1:0]   rd_data;
    logic              rd_valid;
    modport master (
        output fetch, pc, halt, mem_wr, mem_addr, mem_din, rd_req,
        input  rd_data, rd_valid
    );
    modport slave (
        input  fetch, pc, halt, mem_wr, mem_addr, mem_din, rd_req,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: records fetched PCs into a trace buffer and issues halt/timeout pass/fail verdicts
module cpu_trace_monitor #(
    parameter int PC_W    = 9,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    cpu_trace_monitor_if.slave       bus,
    input  logic [ADDR_W-1:0]        chk_addr,
    input  logic [DATA_W-1:0]        chk_val,
    input  logic                     mode,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              count,
    output logic                     overflow,
    output logic                     pass,
    output logic                     fail
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    typedef enum logic [1:0] {ST_RUN = 2'b00, ST_HALT = 2'b01, ST_TMO = 2'b10} state_t;
    state_t            st;
    logic [PC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [WD_W-1:0]   wd;
    logic              fetch_q;
    logic              seen;
    logic [DATA_W-1:0] result;
    logic              ev;
    logic              full;
    logic              run;
    logic              push;
    logic              match;
    assign state = st;
    assign ev    = bus.fetch & ~fetch_q;
    assign full  = level == LVL_W'(DEPTH);
    assign run   = st == ST_RUN;
    // in circular mode a full buffer still takes the write, overwriting the oldest slot
    assign push  = run & ev & (~full | mode);
    assign match = seen && result == chk_val;
    always_ff @(posedge CLOCK_50)
        if (push) mem[wp] <= bus.pc;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            st           <= ST_RUN;
            level        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            wp           <= '0;
            rp           <= '0;
            wd           <= '0;
            fetch_q      <= 1'b0;
            seen         <= 1'b0;
            result       <= '0;
        end else begin
            fetch_q      <= bus.fetch;
            bus.rd_valid <= 1'b0;
            if (run) begin
                if (ev) begin
                    wd    <= '0;
                    count <= count + 16'(count != 16'hFFFF);
                    if (!full) level <= level + LVL_W'(1);
                    else overflow <= 1'b1;
                    if (push) wp <= wp + PTR_W'(1);
                    if (full && mode) rp <= rp + PTR_W'(1);
                end
                if (bus.mem_wr && bus.mem_addr == chk_addr) begin
                    seen   <= 1'b1;
                    result <= bus.mem_din;
                end
                if (bus.halt) begin
                    st   <= ST_HALT;
                    pass <= match;
                    fail <= ~match;
                end else if (!ev) begin
                    if (wd == WD_W'(TIMEOUT - 1)) begin
                        st   <= ST_TMO;
                        fail <= 1'b1;
                    end else wd <= wd + WD_W'(1);
                end
            end else if (bus.rd_req && level != '0) begin
                bus.rd_data  <= mem[rp];
                bus.rd_valid <= 1'b1;
                rp           <= rp + PTR_W'(1);
                level        <= level - LVL_W'(1);
            end
        end
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed stimulus against a queue-based model of the trace monitor
module tb_cpu_trace_monitor;
    localparam int DEPTH = 16;
    localparam int TMO   = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  chk_addr = 8'd25;
    logic [15:0] chk_val = 16'hFFE9;
    logic        mode = 1'b0;
    logic [1:0]  state;
    logic [4:0]  level;
    logic [15:0] count;
    logic        overflow, pass, fail;
    int          n_pass = 0;
    int          n_tot = 0;
    int          q[$];
    int          m_count, m_idle, m_state, m_rdd;
    bit          m_prev, m_seen, m_over, m_pass, m_fail, m_rdv;
    logic [15:0] m_res;

    cpu_trace_monitor_if bus ();

    cpu_trace_monitor #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .bus(bus), .chk_addr(chk_addr), .chk_val(chk_val),
        .mode(mode), .state(state), .level(level), .count(count), .overflow(overflow),
        .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    task automatic model_reset();
        q.delete();
        m_count = 0; m_idle = 0; m_state = 0; m_rdd = 0;
        m_prev = 0; m_seen = 0; m_over = 0; m_pass = 0; m_fail = 0; m_rdv = 0;
        m_res = '0;
    endtask

    task automatic model_step();
        bit ev = bus.fetch && !m_prev;
        bit ok;
        m_prev = bus.fetch;
        m_rdv = 0;
        if (m_state == 0) begin
            if (ev) begin
                if (m_count < 65535) m_count++;
                m_idle = 0;
                if (q.size() < DEPTH) q.push_back(int'(bus.pc));
                else begin
                    m_over = 1;
                    if (mode) begin
                        void'(q.pop_front());
                        q.push_back(int'(bus.pc));
                    end
                end
            end
            if (bus.halt) begin
                ok = m_seen && m_res == chk_val;
                m_state = 1; m_pass = ok; m_fail = !ok;
            end else if (!ev) begin
                m_idle++;
                if (m_idle == TMO) begin m_state = 2; m_fail = 1; end
            end
            if (bus.mem_wr && bus.mem_addr == chk_addr) begin m_seen = 1; m_res = bus.mem_din; end
        end else if (bus.rd_req && q.size() > 0) begin
            m_rdd = q.pop_front();
            m_rdv = 1;
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            chk("state", int'(state), m_state);
            chk("level", int'(level), q.size());
            chk("count", int'(count), m_count);
            chk("overflow", int'(overflow), int'(m_over));
            chk("pass", int'(pass), int'(m_pass));
            chk("fail", int'(fail), int'(m_fail));
            chk("rd_valid", int'(bus.rd_valid), int'(m_rdv));
            if (m_rdv) chk("rd_data", int'(bus.rd_data), m_rdd);
        end

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fetch = 0; bus.pc = '0; bus.halt = 0; bus.mem_wr = 0;
        bus.mem_addr = '0; bus.mem_din = '0; bus.rd_req = 0;
        model_reset();
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_verdict", int'({pass, fail, overflow}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch_pc(int p, int hold);
        bus.fetch = 1; bus.pc = 9'(p);
        repeat (hold) cyc();
        bus.fetch = 0;
        cyc();
    endtask

    task automatic wr(int a, int d);
        bus.mem_wr = 1; bus.mem_addr = 8'(a); bus.mem_din = 16'(d);
        cyc();
        bus.mem_wr = 0;
    endtask

    task automatic do_halt();
        bus.halt = 1;
        cyc();
        bus.halt = 0;
    endtask

    task automatic run_basic(int data, bit do_wr);
        do_reset();
        for (int i = 0; i < 3; i++) fetch_pc(i, 3);
        if (do_wr) wr(25, data);
        do_halt();
        #1;
    endtask

    task automatic run_fill(bit m, int first);
        do_reset();
        mode = m;
        for (int i = 0; i < 20; i++) fetch_pc(i, 1);
        do_halt();
        #1;
        chk("fill_level", int'(level), 16);
        chk("fill_overflow", int'(overflow), 1);
        chk("fill_count", int'(count), 20);
        bus.rd_req = 1;
        cyc();
        #1;
        chk("fill_first", int'(bus.rd_data), first);
        repeat (16) cyc();
        bus.rd_req = 0;
        #1;
        chk("fill_drained", int'(level), 0);
        mode = 0;
    endtask

    initial begin
        #1;
        // matching result word
        run_basic(16'hFFE9, 1);
        chk("t1_count", int'(count), 3);
        chk("t1_level", int'(level), 3);
        chk("t1_pass", int'(pass), 1);
        chk("t1_state", int'(state), 1);
        bus.rd_req = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("t1_rd_valid", int'(bus.rd_valid), int'(i < 3));
            if (i < 3) chk("t1_rd_data", int'(bus.rd_data), i);
        end
        bus.rd_req = 0;
        // mismatching result word
        run_basic(16'h0017, 1);
        chk("t2_fail", int'(fail), 1);
        chk("t2_pass", int'(pass), 0);
        chk("t2_state", int'(state), 1);
        // result never written
        run_basic(16'hFFE9, 0);
        chk("t3_fail", int'(fail), 1);
        // stop-when-full then circular
        run_fill(0, 0);
        run_fill(1, 4);
        // watchdog
        do_reset();
        fetch_pc(9'h1AB, 1);
        repeat (6) cyc();
        #1;
        chk("t5_not_yet", int'(state), 0);
        cyc();
        #1;
        chk("t5_state", int'(state), 2);
        chk("t5_fail", int'(fail), 1);
        bus.rd_req = 1;
        cyc();
        #1;
        chk("t5_rd_data", int'(bus.rd_data), 9'h1AB);
        cyc();
        #1;
        chk("t5_empty", int'(bus.rd_valid), 0);
        bus.rd_req = 0;
        // halt coincident with a fetch event, then reset mid-readout
        do_reset();
        fetch_pc(5, 2);
        fetch_pc(6, 2);
        bus.fetch = 1; bus.pc = 9'd7; bus.halt = 1;
        cyc();
        bus.fetch = 0; bus.halt = 0;
        #1;
        chk("t6_level", int'(level), 3);
        chk("t6_state", int'(state), 1);
        bus.rd_req = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("t6_rd_data", int'(bus.rd_data), 5 + i);
        end
        #1;
        do_reset();
        chk("t6_rst_level", int'(level), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable execution-trace and self-check monitor for the RISC machine. It snoops the CPU's fetch indication, PC and data-memory write port, and records the PC of every fetched instruction into a parametrised trace buffer. It detects halt, watchdog timeout and a pass/fail verdict against an expected result word. It sits beside the CPU in the top level so that on-board runs and benches read the same trace and verdict.

## Interface
Parameters:
- PC_W, 9, PC width
- ADDR_W, 8, data-memory address width
- DATA_W, 16, data-memory word width
- DEPTH, 16, trace entries; power of two, ≥2
- TIMEOUT, 1024, cycles allowed between fetches before watchdog trips; ≥2

Ports:
- CLOCK_50  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch  in  1  high while CPU is in its instruction-fetch state (IF1); level, may stay high several cycles
- pc  in  PC_W  CPU program counter; valid whenever fetch is high
- halt  in  1  CPU break/halt indication (LEDR[8] at top level)
- mem_wr  in  1  data-memory write strobe
- mem_addr  in  ADDR_W  data-memory write address
- mem_din  in  DATA_W  data-memory write data
- chk_addr  in  ADDR_W  address of expected result word; static during a run
- chk_val  in  DATA_W  expected result value; static during a run
- mode  in  1  0 = stop-when-full, 1 = circular; static during a run
- rd_req  in  1  trace readout request, one entry per cycle it is high
- rd_data  out  PC_W  oldest trace entry, valid when rd_valid
- rd_valid  out  1  one-cycle pulse per popped entry
- state  out  2  00 RUN, 01 HALTED, 10 TIMEOUT
- level  out  $clog2(DEPTH)+1  entries held
- count  out  16  fetches seen since reset, saturating at 16'hFFFF
- overflow  out  1  sticky; a fetch arrived while buffer full
- pass  out  1  sticky verdict: halted and result matched
- fail  out  1  sticky verdict: mismatch, result never written, or timeout

## Operation
- Reset (reset_n low, async): state=RUN, level=0, count=0, overflow=0, pass=0, fail=0, rd_valid=0, rd_data=0, pointers=0, watchdog=0, fetch_q=0, seen=0, result=0.
- Fetch detection: fetch_q registers fetch; fetch event = fetch & ~fetch_q. Exactly one entry per fetch state entry, regardless of dwell time. Fetch high during the first cycle after reset counts as an event.
- RUN, on fetch event: pc written at write pointer; count++ (saturating); watchdog cleared.
  - Not full: level++.
  - Full, mode 0: entry dropped, overflow=1, level unchanged.
  - Full, mode 1: oldest overwritten, both pointers advance, overflow=1, level stays DEPTH.
- Result snoop (RUN only): mem_wr with mem_addr==chk_addr sets seen=1, result=mem_din; later writes overwrite.
- RUN → HALTED when halt=1: pass=1 if seen && result==chk_val, else fail=1. A fetch event in the same cycle as halt is still captured.
- RUN → TIMEOUT when watchdog reaches TIMEOUT-1 with no fetch event and no halt: fail=1. Halt takes priority over timeout in the same cycle.
- HALTED, TIMEOUT: terminal until reset. Fetch, halt and mem_wr are ignored.
- Readout (HALTED/TIMEOUT only): rd_req with level>0 pops the oldest entry; rd_req with level=0, or while in RUN, is ignored (rd_valid stays 0). Pointers wrap modulo DEPTH.
- pass and fail are mutually exclusive; never both 1.

## Timing
- Fetch event in cycle N: entry stored and count/level updated at the rising edge ending cycle N; visible in cycle N+1.
- Halt sampled at edge E: state, pass and fail are valid after E.
- Readout: rd_req high in cycle N → rd_data/rd_valid registered at the end of N, valid in N+1; level decrements at the same edge. Back-to-back rd_req yields one entry per cycle.
- Watchdog: TIMEOUT consecutive cycles in RUN with no fetch event → state=TIMEOUT at the end of the TIMEOUT-th cycle.
- Reset asserted mid-run or mid-readout clears everything immediately (asynchronous); no partial entry survives.

## Test plan
- Fetch pulses with PC 0,1,2 (fetch held 3 cycles each), write 16'hFFE9 to chk_addr 25, chk_val=16'hFFE9 (-23), then halt → count=3, level=3, pass=1; three rd_req give 0,1,2, then rd_valid stays 0.
- Same as above but the write data is 16'h0017 → fail=1, pass=0, state=01.
- Halt with no write to chk_addr → fail=1.
- mode=0, DEPTH=16, 20 fetches with PC 0..19, halt → level=16, overflow=1, count=20, readout 0..15; mode=1 same stimulus → readout 4..19.
- TIMEOUT=8, one fetch then idle → state=10 after 8 cycles, fail=1; readout returns that single PC.
- Halt and a fetch event in the same cycle → that PC is the last entry; reset_n low during readout → level=0, state=00, rd_valid=0 at once.
